fft_loader: RTL and testbench
=============================

FFT_LOADER -- requirements
Module: fft_loader

Interface
REQ-001 SHALL have parameter CLEAR_CYCLES, default 2: cycles fft_reset is held high; at least 2 because the FFT core's internal clock runs at clk/2.
REQ-002 SHALL have port clk, input, 1: clock; all logic on posedge clk.
REQ-003 SHALL have port reset, input, 1: synchronous, active-high.
REQ-004 SHALL have port sample_valid, input, 1: upstream audio sample available.
REQ-005 SHALL have port sample_in, input, 16: signed two's-complement audio sample.
REQ-006 SHALL have port sample_ready, output, 1: block accepts a sample this cycle.
REQ-007 SHALL have port load, output, 1: write strobe to the FFT core sample RAM.
REQ-008 SHALL have port load_address, output, 6: FFT RAM write address.
REQ-009 SHALL have port data_out, output, 32: complex word, real in [31:16], imaginary in [15:0].
REQ-010 SHALL have port start, output, 1: one-cycle pulse that starts the FFT.
REQ-011 SHALL have port fft_done, input, 1: FFT core done level, held until the core is reset.
REQ-012 SHALL have port unload_done, input, 1: one-cycle pulse from the downstream reader; all 64 results consumed.
REQ-013 SHALL have port fft_reset, output, 1: reset to the FFT core.
REQ-014 SHALL have port overrun, output, 1: sticky flag; a sample was offered while not ready.
REQ-015 SHALL have port frame_count, output, 8: completed frames, wraps 255->0.

Function
REQ-016 SHALL implement FSM states FILL, KICK, WAIT_FFT, WAIT_DRAIN, CLEAR.
REQ-017 SHALL drive sample_ready = 1 only in FILL; a sample is accepted when sample_valid && sample_ready.
REQ-018 SHALL keep a 6-bit fill counter, 0 on entry to FILL, incremented once per accepted sample.
REQ-019 SHALL register load=1 on the cycle after each acceptance; load=0 otherwise; one cycle latency.
REQ-020 SHALL set load_address to the bit-reverse of the fill counter value at acceptance; count 1 -> 32, count 6 -> 24.
REQ-021 SHALL set data_out = {sample_in, 16'h0000}, registered with load; it holds its value when load=0.
REQ-022 SHALL go FILL->KICK on acceptance of the 64th sample (count 63).
REQ-023 SHALL assert start for exactly one cycle in KICK, the cycle after the final load, never coincident with load, then go to WAIT_FFT.
REQ-024 SHALL go WAIT_FFT->WAIT_DRAIN when fft_done=1.
REQ-025 SHALL go WAIT_DRAIN->CLEAR on unload_done; unload_done in any other state SHALL be ignored.
REQ-026 SHALL hold fft_reset=1 for exactly CLEAR_CYCLES cycles in CLEAR, then go to FILL, clear the fill counter and increment frame_count by 1.
REQ-027 SHALL set overrun when sample_valid=1 and sample_ready=0; the sample is dropped; overrun clears only on reset.
REQ-028 SHALL ignore fft_done outside WAIT_FFT.

Reset
REQ-029 SHALL on reset enter CLEAR with fft_reset=1, so the FFT core is also reset (CLEAR_CYCLES cycles after reset deasserts).
REQ-030 SHALL on reset clear the fill counter, frame_count and overrun, and drive load=0, start=0, load_address=0, data_out=0.
REQ-031 SHALL discard a partial frame if reset occurs mid-FILL; after reset, filling restarts at count 0.

Structure
REQ-032 SHALL take the FSM state enum, FFT_LOG2N=6 and FFT_N=64 from the shared fft package.
REQ-033 SHALL implement bit reversal as a function in that package, not as a sub-module.
REQ-034 SHALL be a single module with no sub-modules.

Verification
REQ-035 Reset then 64 back-to-back samples 0..63: load pulses at count k go to bitrev(k), data_out=k<<16; start is one pulse two cycles after the last acceptance.
REQ-036 Sample 16'h8001 at count 1 -> load_address=32, data_out=32'h80010000.
REQ-037 sample_valid held during WAIT_FFT -> sample_ready=0, overrun=1 and stays 1; no load pulses occur.
REQ-038 fft_done=1 then unload_done pulse -> fft_reset high exactly 2 cycles, then FILL; frame_count 0->1.
REQ-039 Reset after 20 samples accepted -> next frame's first sample writes address 0; frame_count=0.
REQ-040 256 full frames -> frame_count wraps to 0; an unload_done pulse during FILL has no effect.

Source files
------------

// File: rtl/fft_loader_pkg.sv
// Shared FFT definitions: transform size, loader FSM states and the
// bit-reversal helper used to place samples in the core's RAM.
package fft_loader_pkg;

  localparam int unsigned FFT_LOG2N = 6;
  localparam int unsigned FFT_N     = 1 << FFT_LOG2N;

  typedef enum logic [2:0] {
    FILL,
    KICK,
    WAIT_FFT,
    WAIT_DRAIN,
    CLEAR
  } loader_state_e;

  // Mirror the address bits so samples land in bit-reversed order.
  function automatic logic [FFT_LOG2N-1:0] bitrev(input logic [FFT_LOG2N-1:0] v);
    logic [FFT_LOG2N-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < FFT_LOG2N; i++) begin
      r[i] = v[FFT_LOG2N-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_loader.sv
// fft_loader: collects 64 audio samples into the FFT core's RAM in
// bit-reversed order, kicks the transform, waits for the results to be
// drained, then resets the core before starting the next frame.
module fft_loader
  import fft_loader_pkg::*;
#(
  parameter int unsigned CLEAR_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sample_valid,
  input  logic [15:0]          sample_in,
  output logic                 sample_ready,
  output logic                 load,
  output logic [FFT_LOG2N-1:0] load_address,
  output logic [31:0]          data_out,
  output logic                 start,
  input  logic                 fft_done,
  input  logic                 unload_done,
  output logic                 fft_reset,
  output logic                 overrun,
  output logic [7:0]           frame_count
);

  localparam int unsigned          CW        = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
  localparam logic [CW-1:0]        CLR_LAST  = CW'(CLEAR_CYCLES - 1);
  localparam logic [FFT_LOG2N-1:0] FILL_LAST = FFT_LOG2N'(FFT_N - 1);

  loader_state_e        state_q, state_d;
  logic [FFT_LOG2N-1:0] fill_q, fill_d;
  logic [CW-1:0]        clr_q, clr_d;
  logic                 frame_pend_q, frame_pend_d;
  logic                 load_q, load_d;
  logic [FFT_LOG2N-1:0] addr_q, addr_d;
  logic [31:0]          data_q, data_d;
  logic                 start_q, start_d;
  logic                 overrun_q, overrun_d;
  logic [7:0]           frame_q, frame_d;
  logic                 accept;

  assign sample_ready = (state_q == FILL);
  assign fft_reset    = (state_q == CLEAR);
  assign accept       = sample_valid && sample_ready;

  assign load         = load_q;
  assign load_address = addr_q;
  assign data_out     = data_q;
  assign start        = start_q;
  assign overrun      = overrun_q;
  assign frame_count  = frame_q;

  // Next-state and registered-output computation for the frame sequencer.
  // start is registered out of KICK so it lands one cycle after the final
  // load strobe instead of overlapping it.
  always_comb begin
    state_d      = state_q;
    fill_d       = fill_q;
    clr_d        = clr_q;
    frame_pend_d = frame_pend_q;
    load_d       = 1'b0;
    addr_d       = addr_q;
    data_d       = data_q;
    start_d      = 1'b0;
    overrun_d    = overrun_q;
    frame_d      = frame_q;

    if (sample_valid && !sample_ready) begin
      overrun_d = 1'b1;
    end

    case (state_q)
      FILL: begin
        if (accept) begin
          load_d = 1'b1;
          addr_d = bitrev(fill_q);
          data_d = {sample_in, 16'h0000};
          fill_d = fill_q + 1'b1;
          if (fill_q == FILL_LAST) begin
            state_d = KICK;
          end
        end
      end
      KICK: begin
        start_d = 1'b1;
        state_d = WAIT_FFT;
      end
      WAIT_FFT: begin
        if (fft_done) begin
          state_d = WAIT_DRAIN;
        end
      end
      WAIT_DRAIN: begin
        if (unload_done) begin
          state_d      = CLEAR;
          clr_d        = '0;
          frame_pend_d = 1'b1;
        end
      end
      CLEAR: begin
        // Only a frame that was actually drained bumps the counter; the
        // CLEAR pass that follows reset does not.
        if (clr_q == CLR_LAST) begin
          state_d      = FILL;
          fill_d       = '0;
          clr_d        = '0;
          frame_pend_d = 1'b0;
          if (frame_pend_q) begin
            frame_d = frame_q + 8'd1;
          end
        end else begin
          clr_d = clr_q + 1'b1;
        end
      end
      default: begin
        state_d = CLEAR;
        clr_d   = '0;
      end
    endcase
  end

  // State and output registers; reset parks the core in CLEAR.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= CLEAR;
      fill_q       <= '0;
      clr_q        <= '0;
      frame_pend_q <= 1'b0;
      load_q       <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      start_q      <= 1'b0;
      overrun_q    <= 1'b0;
      frame_q      <= '0;
    end else begin
      state_q      <= state_d;
      fill_q       <= fill_d;
      clr_q        <= clr_d;
      frame_pend_q <= frame_pend_d;
      load_q       <= load_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      start_q      <= start_d;
      overrun_q    <= overrun_d;
      frame_q      <= frame_d;
    end
  end

endmodule

// File: tb/tb_fft_loader.sv
// Self-checking bench for fft_loader: constant vector table, a frame-level
// reference model compared every cycle, and directed corner sequences.
module tb_fft_loader;

  localparam int CC = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        sample_valid = 1'b0;
  logic [15:0] sample_in = '0;
  logic        fft_done = 1'b0;
  logic        unload_done = 1'b0;
  logic        sample_ready, load, start, fft_reset, overrun;
  logic [5:0]  load_address;
  logic [31:0] data_out;
  logic [7:0]  frame_count;

  fft_loader #(.CLEAR_CYCLES(CC)) dut (
    .clk(clk), .reset(reset), .sample_valid(sample_valid), .sample_in(sample_in),
    .sample_ready(sample_ready), .load(load), .load_address(load_address),
    .data_out(data_out), .start(start), .fft_done(fft_done),
    .unload_done(unload_done), .fft_reset(fft_reset), .overrun(overrun),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n_load = 0;
  int n_start = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: frame progress expressed as samples collected, pending
  // handshakes and remaining clear cycles.
  int          m_acc, m_clear_left, m_frame, frames_done;
  bit          m_kick, m_wait_done, m_wait_drain, m_count_frame;
  bit          m_load, m_start, m_overrun;
  logic [5:0]  m_addr;
  logic [31:0] m_data;

  function automatic int rev6(input int k);
    int r;
    r = 0;
    for (int b = 0; b < 6; b++) if (((k >> b) & 1) != 0) r += 1 << (5 - b);
    return r;
  endfunction

  function automatic bit m_ready();
    return (m_clear_left == 0) && (m_acc < 64);
  endfunction

  task automatic model_step();
    if (reset) begin
      m_acc = 0; m_clear_left = CC; m_frame = 0; m_count_frame = 0;
      m_kick = 0; m_wait_done = 0; m_wait_drain = 0;
      m_load = 0; m_start = 0; m_overrun = 0; m_addr = '0; m_data = '0;
    end else begin
      if (sample_valid && !m_ready()) m_overrun = 1;
      m_load = 0; m_start = 0;
      if (m_clear_left > 0) begin
        m_clear_left--;
        if (m_clear_left == 0) begin
          m_acc = 0;
          if (m_count_frame) begin
            m_frame = (m_frame + 1) % 256;
            frames_done++;
          end
          m_count_frame = 0;
        end
      end else if (m_acc < 64) begin
        if (sample_valid) begin
          m_load = 1; m_addr = 6'(rev6(m_acc)); m_data = {sample_in, 16'h0000};
          m_acc++;
          if (m_acc == 64) m_kick = 1;
        end
      end else if (m_kick) begin
        m_kick = 0; m_start = 1; m_wait_done = 1;
      end else if (m_wait_done) begin
        if (fft_done) begin m_wait_done = 0; m_wait_drain = 1; end
      end else if (m_wait_drain) begin
        if (unload_done) begin m_wait_drain = 0; m_clear_left = CC; m_count_frame = 1; end
      end
    end
  endtask

  task automatic sample_point(input bit cmp);
    @(negedge clk);
    if (load === 1'b1) n_load++;
    if (start === 1'b1) n_start++;
    if (cmp) begin
      chk("ready", 32'(sample_ready), 32'(m_ready()));
      chk("fft_reset", 32'(fft_reset), 32'(m_clear_left > 0));
      chk("load", 32'(load), 32'(m_load));
      chk("load_address", 32'(load_address), 32'(m_addr));
      chk("data_out", data_out, m_data);
      chk("start", 32'(start), 32'(m_start));
      chk("overrun", 32'(overrun), 32'(m_overrun));
      chk("frame_count", 32'(frame_count), 32'(m_frame));
    end
  endtask

  task automatic advance();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    reset = 1; sample_valid = 0; fft_done = 0; unload_done = 0;
    repeat (n) begin sample_point(0); advance(); end
    reset = 0;
  endtask

  task automatic idle(input int n);
    sample_valid = 0; unload_done = 0;
    repeat (n) begin sample_point(1); advance(); end
  endtask

  typedef struct {
    logic sv; logic [15:0] smp;
    logic ready, load; logic [5:0] addr; logic [31:0] data; logic start, frst;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int base, frst_cnt, cyc;
    bit pend;

    tbl[0] = '{1'b0, 16'h0000, 1'b0, 1'b0, 6'd0,  32'h00000000, 1'b0, 1'b1};
    tbl[1] = '{1'b0, 16'h0000, 1'b0, 1'b0, 6'd0,  32'h00000000, 1'b0, 1'b1};
    tbl[2] = '{1'b1, 16'h1234, 1'b1, 1'b0, 6'd0,  32'h00000000, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 16'h8001, 1'b1, 1'b1, 6'd0,  32'h12340000, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 16'h0000, 1'b1, 1'b1, 6'd32, 32'h80010000, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 16'h00FF, 1'b1, 1'b0, 6'd32, 32'h80010000, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 16'h0000, 1'b1, 1'b1, 6'd16, 32'h00FF0000, 1'b0, 1'b0};
    tbl[7] = '{1'b0, 16'h0000, 1'b1, 1'b0, 6'd16, 32'h00FF0000, 1'b0, 1'b0};

    // Reset state and the first few loads from the constant table.
    frames_done = 0;
    do_reset(2);
    for (int i = 0; i < 8; i++) begin
      sample_valid = tbl[i].sv; sample_in = tbl[i].smp;
      @(negedge clk);
      chk("tbl_ready", 32'(sample_ready), 32'(tbl[i].ready));
      chk("tbl_load", 32'(load), 32'(tbl[i].load));
      chk("tbl_addr", 32'(load_address), 32'(tbl[i].addr));
      chk("tbl_data", data_out, tbl[i].data);
      chk("tbl_start", 32'(start), 32'(tbl[i].start));
      chk("tbl_fft_reset", 32'(fft_reset), 32'(tbl[i].frst));
      chk("tbl_overrun", 32'(overrun), 32'(0));
      chk("tbl_frame", 32'(frame_count), 32'(0));
      advance();
    end

    // 64 back-to-back samples 0..63; start two cycles after the last accept.
    do_reset(1);
    idle(CC);
    n_load = 0; n_start = 0;
    for (int k = 0; k < 64; k++) begin
      sample_valid = 1; sample_in = 16'(k);
      sample_point(1); advance();
    end
    sample_valid = 0;
    sample_point(1); chk("last_load", 32'(load), 32'(1)); chk("start_early", 32'(start), 32'(0)); advance();
    sample_point(1); chk("start_pulse", 32'(start), 32'(1)); chk("start_load", 32'(load), 32'(0)); advance();
    sample_point(1); chk("start_end", 32'(start), 32'(0)); advance();
    chk("frame_loads", 32'(n_load), 32'(64));
    chk("frame_starts", 32'(n_start), 32'(1));

    // Samples offered while waiting on the core: dropped, overrun sticks.
    chk("overrun_before", 32'(overrun), 32'(0));
    base = n_load;
    sample_valid = 1;
    for (int i = 0; i < 10; i++) begin
      sample_in = 16'($urandom);
      sample_point(1); chk("ready_wait", 32'(sample_ready), 32'(0)); advance();
    end
    sample_valid = 0;
    idle(1);
    chk("overrun_set", 32'(overrun), 32'(1));
    chk("no_loads_wait", 32'(n_load - base), 32'(0));

    // fft_done then unload_done: exactly CC cycles of fft_reset, frame 0->1.
    fft_done = 1;
    idle(3);
    unload_done = 1;
    sample_point(1); advance();
    unload_done = 0; fft_done = 0;
    frst_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      sample_point(1);
      if (fft_reset === 1'b1) frst_cnt++;
      advance();
    end
    chk("clear_len", 32'(frst_cnt), 32'(CC));
    chk("frame_after", 32'(frame_count), 32'(1));
    chk("ready_after", 32'(sample_ready), 32'(1));
    chk("overrun_sticky", 32'(overrun), 32'(1));

    // Reset part-way through a frame: refill restarts at address 0.
    for (int k = 0; k < 20; k++) begin
      sample_valid = 1; sample_in = 16'(k + 100);
      sample_point(1); advance();
    end
    do_reset(1);
    idle(CC);
    sample_valid = 1; sample_in = 16'h7FFF;
    sample_point(1); advance();
    sample_valid = 0;
    sample_point(1);
    chk("restart_load", 32'(load), 32'(1));
    chk("restart_addr", 32'(load_address), 32'(0));
    chk("restart_data", data_out, 32'h7FFF0000);
    chk("restart_frame", 32'(frame_count), 32'(0));
    advance();

    // Randomised traffic including stray handshakes and occasional resets.
    pend = 0;
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 599) == 0);
      sample_valid = ($urandom_range(0, 3) != 0);
      sample_in = 16'($urandom);
      if (m_clear_left > 0) pend = 0;
      else if ($urandom_range(0, 19) == 0) pend = 1;
      fft_done = pend;
      unload_done = ($urandom_range(0, 15) == 0);
      sample_point(1); advance();
    end
    reset = 0; fft_done = 0; unload_done = 0;

    // 256 full frames: frame_count wraps; unload_done in FILL is ignored.
    do_reset(1);
    frames_done = 0;
    cyc = 0;
    pend = 0;
    while (frames_done < 256 && cyc < 256 * 80) begin
      sample_valid = m_ready();
      sample_in = 16'($urandom);
      fft_done = (m_acc == 64) && (m_clear_left == 0);
      unload_done = m_wait_drain;
      if (frames_done == 0 && m_acc == 10 && m_clear_left == 0 && !pend) begin
        unload_done = 1; pend = 1;
        sample_point(1); advance();
        unload_done = 0;
        sample_point(1);
        chk("fill_unload_ready", 32'(sample_ready), 32'(1));
        chk("fill_unload_frst", 32'(fft_reset), 32'(0));
        advance();
        cyc += 2;
      end else begin
        sample_point(1);
        if (frames_done == 255 && m_clear_left == 0 && m_acc == 0)
          chk("frame_255", 32'(frame_count), 32'(255));
        advance();
        cyc++;
      end
    end
    sample_valid = 0; fft_done = 0; unload_done = 0;
    chk("frames_completed", 32'(frames_done), 32'(256));
    idle(1);
    chk("frame_wrap", 32'(frame_count), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
